// File: rtl/raiz_pkg.sv
// rtl/raiz_pkg.sv - shared types and width helpers for the integer square-root unit
// Purpose: FSM state encoding and result-width helpers used by raiz_n, raiz_n_if and raiz_step.
// Ports: none (package).
package raiz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Root width for a given radicand width.
  function automatic int raiz_w_root(input int width);
    return width / 2;
  endfunction

  // Final remainder width; the remainder never exceeds 2*root.
  function automatic int raiz_w_rem(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/raiz_n_if.sv
// rtl/raiz_n_if.sv - start/result handshake bundle for the square-root unit
// Purpose: groups the request (init, in_RR) and result (out_*) signals of raiz_n.
// Ports:
//   init      start request
//   in_RR     WIDTH-bit unsigned radicand
//   out_Q     WIDTH/2-bit root
//   out_R     WIDTH/2+1-bit remainder
//   out_DONE  one-cycle result-valid pulse
//   out_BUSY  operation in progress
//   out_EXACT remainder is zero
// Modports: master drives requests, slave (the unit) drives results.
interface raiz_n_if #(
  parameter int WIDTH = 16
);
  import raiz_pkg::*;

  logic                          init;
  logic [WIDTH-1:0]              in_RR;
  logic [raiz_w_root(WIDTH)-1:0] out_Q;
  logic [raiz_w_rem(WIDTH)-1:0]  out_R;
  logic                          out_DONE;
  logic                          out_BUSY;
  logic                          out_EXACT;

  modport master (
    output init, in_RR,
    input  out_Q, out_R, out_DONE, out_BUSY, out_EXACT
  );

  modport slave (
    input  init, in_RR,
    output out_Q, out_R, out_DONE, out_BUSY, out_EXACT
  );

endinterface

// File: rtl/raiz_n_step.sv
// rtl/raiz_n_step.sv - one restoring iteration of the digit-by-digit square root
// Purpose: combinational cell producing the next working remainder and next root bit.
// Ports:
//   rem_i   current working remainder (WIDTH/2+2 bits)
//   root_i  root bits developed so far (WIDTH/2 bits)
//   rad_i   next two radicand bits (MSB pair)
//   rem_o   next working remainder
//   bit_o   next root bit
module raiz_step
  import raiz_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int WQ    = raiz_w_root(WIDTH),
  localparam int WM    = WQ + 2
) (
  input  logic [WM-1:0] rem_i,
  input  logic [WQ-1:0] root_i,
  input  logic [1:0]    rad_i,
  output logic [WM-1:0] rem_o,
  output logic          bit_o
);

  logic [WM-1:0] trial;
  logic [WM-1:0] test;

  // The top two remainder bits are always zero here (rem <= 2*root), so the
  // shift loses nothing and the whole compare fits in WM bits.
  assign trial = (rem_i << 2) | WM'(rad_i);
  assign test  = {root_i, 2'b01};
  assign bit_o = (trial >= test);
  assign rem_o = bit_o ? (trial - test) : trial;

endmodule

// File: rtl/raiz_n.sv
// rtl/raiz_n.sv - parametrised integer square root, one root bit per clock
// Purpose: computes floor(sqrt(in_RR)) and in_RR - root^2 with a busy/done handshake.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  raiz_n_if slave: init/in_RR in, out_Q/out_R/out_DONE/out_BUSY/out_EXACT out
module raiz_n
  import raiz_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH / 2 + 1)
) (
  input  logic       clk,
  input  logic       rst,
  raiz_n_if.slave    bus
);

  localparam int WQ = raiz_w_root(WIDTH);
  localparam int WR = raiz_w_rem(WIDTH);
  localparam int WM = WQ + 2;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("raiz_n: WIDTH must be even and >= 4");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rad_q,   rad_d;
  logic [WM-1:0]    rem_q,   rem_d;
  logic [WQ-1:0]    root_q,  root_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WQ-1:0]    q_q,     q_d;
  logic [WR-1:0]    r_q,     r_d;
  logic             exact_q, exact_d;

  logic [WM-1:0]    step_rem;
  logic             step_bit;

  raiz_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .rad_i  (rad_q[WIDTH-1:WIDTH-2]),
    .rem_o  (step_rem),
    .bit_o  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    exact_d = exact_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request exactly like IDLE for back-to-back use.
        if (bus.init) begin
          rad_d   = bus.in_RR;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CNT_W'(WQ);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d  = step_rem;
        root_d = {root_q[WQ-2:0], step_bit};
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Results are published only on the final iteration.
          state_d = DONE;
          q_d     = {root_q[WQ-2:0], step_bit};
          r_d     = step_rem[WR-1:0];
          exact_d = (step_rem == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      exact_q <= exact_d;
    end
  end

  assign bus.out_Q     = q_q;
  assign bus.out_R     = r_q;
  assign bus.out_EXACT = exact_q;
  assign bus.out_DONE  = (state_q == DONE);
  assign bus.out_BUSY  = (state_q == CALC);

endmodule

// File: tb/tb_raiz_n.sv
// tb/tb_raiz_n.sv - self-checking bench for raiz_n at WIDTH=16 and WIDTH=32
module tb_raiz_n;
  import raiz_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  raiz_n_if #(.WIDTH(16)) bus16 ();
  raiz_n_if #(.WIDTH(32)) bus32 ();

  raiz_n #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  raiz_n #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  typedef struct {
    longint unsigned q;
    longint unsigned r;
    bit              ex;
  } exp_t;

  exp_t sb16[$];
  exp_t sb32[$];
  exp_t e16, e32;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int done16_n = 0, done16_cyc = 0, busy16_n = 0;
  int done32_n = 0, done32_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input longint unsigned x);
    exp_t e;
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 32;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    e.q  = lo;
    e.r  = x - lo * lo;
    e.ex = (e.r == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus16.out_BUSY) busy16_n++;
    if (bus16.out_DONE) begin
      done16_n++;
      done16_cyc = cyc;
      if (sb16.size() == 0) check("done16_unexpected", bus16.out_DONE, 0);
      else begin
        e16 = sb16.pop_front();
        check("q16", bus16.out_Q, e16.q);
        check("r16", bus16.out_R, e16.r);
        check("exact16", bus16.out_EXACT, e16.ex);
      end
    end
    if (bus32.out_DONE) begin
      done32_n++;
      done32_cyc = cyc;
      if (sb32.size() == 0) check("done32_unexpected", bus32.out_DONE, 0);
      else begin
        e32 = sb32.pop_front();
        check("q32", bus32.out_Q, e32.q);
        check("r32", bus32.out_R, e32.r);
        check("exact32", bus32.out_EXACT, e32.ex);
      end
    end
  end

  task automatic go16(input logic [15:0] x, input bit push, output int c0);
    bus16.in_RR = x;
    bus16.init  = 1'b1;
    if (push) sb16.push_back(model(x));
    @(posedge clk);
    #1;
    c0 = cyc;
    bus16.init = 1'b0;
  endtask

  task automatic wait16(input int n_before, output int c);
    for (int i = 0; i < 40 && done16_n == n_before; i++) @(negedge clk);
    check("done16_seen", done16_n > n_before, 1);
    c = done16_cyc;
  endtask

  task automatic go32(input logic [31:0] x, output int c0);
    bus32.in_RR = x;
    bus32.init  = 1'b1;
    sb32.push_back(model(x));
    @(posedge clk);
    #1;
    c0 = cyc;
    bus32.init = 1'b0;
  endtask

  task automatic wait32(input int n_before, output int c);
    for (int i = 0; i < 60 && done32_n == n_before; i++) @(negedge clk);
    check("done32_seen", done32_n > n_before, 1);
    c = done32_cyc;
  endtask

  initial begin
    int c0, c1, c2, n0, b0;
    rst = 1'b1;
    bus16.init = 1'b0; bus16.in_RR = '0;
    bus32.init = 1'b0; bus32.in_RR = '0;
    #12;
    check("rst_q", bus16.out_Q, 0);
    check("rst_r", bus16.out_R, 0);
    check("rst_done", bus16.out_DONE, 0);
    check("rst_busy", bus16.out_BUSY, 0);
    check("rst_exact", bus16.out_EXACT, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // 144: latency and busy length
    n0 = done16_n; b0 = busy16_n;
    go16(16'd144, 1'b1, c0);
    wait16(n0, c1);
    check("lat144", c1 - c0, 8);
    check("busy144", busy16_n - b0, 8);
    @(posedge clk); #1;
    check("hold_q", bus16.out_Q, 12);
    check("hold_exact", bus16.out_EXACT, 1);

    // max and zero radicand
    n0 = done16_n; go16(16'hFFFF, 1'b1, c0); wait16(n0, c1);
    n0 = done16_n; go16(16'd0, 1'b1, c0); wait16(n0, c1);
    @(posedge clk); #1;

    // back-to-back with init held high
    n0 = done16_n;
    bus16.in_RR = 16'd2;
    bus16.init  = 1'b1;
    sb16.push_back(model(2));
    sb16.push_back(model(65025));
    @(posedge clk); #1;
    bus16.in_RR = 16'd65025;
    wait16(n0, c1);
    @(posedge clk); #1;
    bus16.init = 1'b0;
    wait16(n0 + 1, c2);
    check("b2b_gap", c2 - c1, 9);

    // WIDTH=32
    n0 = done32_n; go32(32'hFFFF_FFFF, c0); wait32(n0, c1);
    check("lat32", c1 - c0, 16);
    n0 = done32_n; go32(32'd1000000, c0); wait32(n0, c1);

    // init and in_RR disturbed during CALC
    @(posedge clk); #1;
    n0 = done16_n;
    go16(16'd1000, 1'b1, c0);
    repeat (3) begin @(posedge clk); #1; end
    bus16.in_RR = 16'd5;
    bus16.init  = 1'b1;
    @(posedge clk); #1;
    bus16.init = 1'b0;
    wait16(n0, c1);
    check("disturb_lat", c1 - c0, 8);
    @(posedge clk); #1;

    // async reset at iteration 4
    n0 = done16_n;
    go16(16'd50000, 1'b0, c0);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("abort_q", bus16.out_Q, 0);
    check("abort_r", bus16.out_R, 0);
    check("abort_done", bus16.out_DONE, 0);
    check("abort_busy", bus16.out_BUSY, 0);
    check("abort_exact", bus16.out_EXACT, 0);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done16_n, n0);
    go16(16'd99, 1'b1, c0);
    wait16(n0, c1);
    @(posedge clk); #1;

    check("sb16_empty", sb16.size(), 0);
    check("sb32_empty", sb32.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
